// File: rtl/game_flow_ctrl.sv
// Frame-rate game sequencer: debounced start, READY UP blink, 3-2-1 countdown,
// lives tracking and a timed GAME OVER hold. All outputs are registered.
module game_flow_ctrl #(
    parameter int unsigned LIVES_INIT      = 3,
    parameter int unsigned DEBOUNCE_FRAMES = 3,
    parameter int unsigned BLINK_FRAMES    = 30,
    parameter int unsigned STEP_FRAMES     = 60,
    parameter int unsigned GAMEOVER_FRAMES = 300
) (
    input  logic       i_pixel_clk,
    input  logic       i_rst_n,
    input  logic       i_fsync,
    input  logic       i_btn_start,
    input  logic       i_player_hit,
    output logic [1:0] o_game_state,
    output logic       o_show_ready,
    output logic [1:0] o_countdown_val,
    output logic [1:0] o_lives,
    output logic       o_game_reset
);

    localparam int unsigned MaxFrames =
        (BLINK_FRAMES > STEP_FRAMES) ?
            ((BLINK_FRAMES > GAMEOVER_FRAMES) ? BLINK_FRAMES : GAMEOVER_FRAMES) :
            ((STEP_FRAMES > GAMEOVER_FRAMES) ? STEP_FRAMES : GAMEOVER_FRAMES);
    localparam int unsigned FW = (MaxFrames > 1) ? $clog2(MaxFrames) : 1;
    localparam int unsigned DW = $clog2(DEBOUNCE_FRAMES + 1);

    localparam logic [FW-1:0] BlinkLast = FW'(BLINK_FRAMES - 1);
    localparam logic [FW-1:0] StepLast  = FW'(STEP_FRAMES - 1);
    localparam logic [FW-1:0] OverLast  = FW'(GAMEOVER_FRAMES - 1);
    localparam logic [DW-1:0] DebMax    = DW'(DEBOUNCE_FRAMES);
    localparam logic [1:0]    LivesLoad = 2'(LIVES_INIT);

    typedef enum logic [1:0] {
        StStart     = 2'd0,
        StCountdown = 2'd1,
        StPlaying   = 2'd2,
        StGameOver  = 2'd3
    } state_e;

    state_e        r_state, w_state_d;
    logic [FW-1:0] r_frame_cnt, w_frame_cnt_d;
    logic [DW-1:0] r_deb_cnt, w_deb_cnt_d;
    logic          r_show_ready, w_show_ready_d;
    logic [1:0]    r_cd_val, w_cd_val_d;
    logic [1:0]    r_lives, w_lives_d;
    logic          r_game_reset, w_game_reset_d;
    logic          w_press;

    // A press fires only on the sample that brings the counter up to DebMax.
    assign w_press = i_fsync && i_btn_start && (r_deb_cnt == DebMax - DW'(1));

    always_ff @(posedge i_pixel_clk) begin
        if (!i_rst_n) begin
            r_state      <= StStart;
            r_frame_cnt  <= '0;
            r_deb_cnt    <= '0;
            r_show_ready <= 1'b1;
            r_cd_val     <= 2'd0;
            r_lives      <= 2'd0;
            r_game_reset <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_frame_cnt  <= w_frame_cnt_d;
            r_deb_cnt    <= w_deb_cnt_d;
            r_show_ready <= w_show_ready_d;
            r_cd_val     <= w_cd_val_d;
            r_lives      <= w_lives_d;
            r_game_reset <= w_game_reset_d;
        end
    end

    always_comb begin
        w_state_d      = r_state;
        w_frame_cnt_d  = r_frame_cnt;
        w_deb_cnt_d    = r_deb_cnt;
        w_show_ready_d = 1'b1;
        w_cd_val_d     = r_cd_val;
        w_lives_d      = r_lives;
        w_game_reset_d = 1'b0;

        if (i_fsync) begin
            if (!i_btn_start) begin
                w_deb_cnt_d = '0;
            end else if (r_deb_cnt != DebMax) begin
                w_deb_cnt_d = r_deb_cnt + DW'(1);
            end
        end

        unique case (r_state)
            StStart: begin
                w_show_ready_d = r_show_ready;
                w_cd_val_d     = 2'd0;
                if (w_press) begin
                    w_state_d      = StCountdown;
                    w_cd_val_d     = 2'd3;
                    w_lives_d      = LivesLoad;
                    w_frame_cnt_d  = '0;
                    w_game_reset_d = 1'b1;
                    w_show_ready_d = 1'b1;
                end else if (i_fsync) begin
                    if (r_frame_cnt == BlinkLast) begin
                        w_frame_cnt_d  = '0;
                        w_show_ready_d = !r_show_ready;
                    end else begin
                        w_frame_cnt_d = r_frame_cnt + FW'(1);
                    end
                end
            end
            StCountdown: begin
                if (i_fsync) begin
                    if (r_frame_cnt == StepLast) begin
                        w_frame_cnt_d = '0;
                        if (r_cd_val == 2'd1) begin
                            w_state_d  = StPlaying;
                            w_cd_val_d = 2'd0;
                        end else begin
                            w_cd_val_d = r_cd_val - 2'd1;
                        end
                    end else begin
                        w_frame_cnt_d = r_frame_cnt + FW'(1);
                    end
                end
            end
            StPlaying: begin
                w_cd_val_d = 2'd0;
                if (i_player_hit) begin
                    if (r_lives == 2'd1) begin
                        w_lives_d     = 2'd0;
                        w_state_d     = StGameOver;
                        w_frame_cnt_d = '0;
                    end else begin
                        w_lives_d = r_lives - 2'd1;
                    end
                end
            end
            StGameOver: begin
                w_cd_val_d = 2'd0;
                if (i_fsync) begin
                    if (r_frame_cnt == OverLast) begin
                        w_state_d     = StStart;
                        w_frame_cnt_d = '0;
                    end else begin
                        w_frame_cnt_d = r_frame_cnt + FW'(1);
                    end
                end
            end
            default: begin
                w_state_d = StStart;
            end
        endcase
    end

    assign o_game_state    = r_state;
    assign o_show_ready    = r_show_ready;
    assign o_countdown_val = r_cd_val;
    assign o_lives         = r_lives;
    assign o_game_reset    = r_game_reset;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: a vector table walks the game through every
// state, then a hand-written sequence covers a reset in the middle of GAME OVER.
module tb_game_flow_ctrl;

    logic       clk;
    logic       rst_n;
    logic       fsync;
    logic       btn;
    logic       hit;
    logic [1:0] game_state;
    logic       show_ready;
    logic [1:0] countdown_val;
    logic [1:0] lives;
    logic       game_reset;

    int n_total;
    int n_pass;
    int n_grst;

    game_flow_ctrl dut (
        .i_pixel_clk    (clk),
        .i_rst_n        (rst_n),
        .i_fsync        (fsync),
        .i_btn_start    (btn),
        .i_player_hit   (hit),
        .o_game_state   (game_state),
        .o_show_ready   (show_ready),
        .o_countdown_val(countdown_val),
        .o_lives        (lives),
        .o_game_reset   (game_reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (game_reset === 1'b1) n_grst++;
    end

    // reps active cycles, each followed by one idle cycle except the last;
    // outputs are checked right after the last active cycle.
    typedef struct {
        string      name;
        int         reps;
        logic       rst_n;
        logic       fsync;
        logic       btn;
        logic       hit;
        logic [1:0] st;
        logic       show;
        logic [1:0] cd;
        logic [1:0] lv;
        logic       grst;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string name, input int reps, input logic r, input logic f,
                       input logic b, input logic h, input logic [1:0] st, input logic show,
                       input logic [1:0] cd, input logic [1:0] lv, input logic grst);
        vec_t v;
        v = '{name, reps, r, f, b, h, st, show, cd, lv, grst};
        vecs.push_back(v);
    endtask

    task automatic cycle(input logic r, input logic f, input logic b, input logic h);
        rst_n = r;
        fsync = f;
        btn   = b;
        hit   = h;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [1:0] st, input logic show,
                         input logic [1:0] cd, input logic [1:0] lv, input logic grst);
        logic [7:0] got;
        logic [7:0] exp;
        got = {game_state, show_ready, countdown_val, lives, game_reset};
        exp = {st, show, cd, lv, grst};
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got st=%0d show=%0b cd=%0d lives=%0d grst=%0b, want st=%0d show=%0b cd=%0d lives=%0d grst=%0b",
                     name, game_state, show_ready, countdown_val, lives, game_reset,
                     st, show, cd, lv, grst);
        end
    endtask

    task automatic apply(input vec_t v);
        for (int r = 0; r < v.reps; r++) begin
            cycle(v.rst_n, v.fsync, v.btn, v.hit);
            if (r < v.reps - 1) cycle(v.rst_n, 1'b0, v.btn, 1'b0);
        end
        check(v.name, v.st, v.show, v.cd, v.lv, v.grst);
    endtask

    task automatic frames(input int n, input logic b);
        for (int i = 0; i < n; i++) begin
            cycle(1'b1, 1'b1, b, 1'b0);
            cycle(1'b1, 1'b0, b, 1'b0);
        end
    endtask

    initial begin
        int grst_before;
        n_total = 0;
        n_pass  = 0;
        n_grst  = 0;
        rst_n   = 1'b0;
        fsync   = 1'b0;
        btn     = 1'b0;
        hit     = 1'b0;

        //   name            reps rst fs btn hit  st show cd lv grst
        add("reset",            5, 0, 1, 1, 0,  0, 1, 0, 0, 0);
        add("deb_2_after_rst",  2, 1, 1, 1, 0,  0, 1, 0, 0, 0);
        add("deb_3_after_rst",  1, 1, 1, 1, 0,  1, 1, 3, 3, 1);
        add("grst_drops",       1, 1, 0, 1, 0,  1, 1, 3, 3, 0);
        add("reset_again",      2, 0, 1, 1, 0,  0, 1, 0, 0, 0);
        add("blink_29",        29, 1, 1, 0, 0,  0, 1, 0, 0, 0);
        add("blink_30",         1, 1, 1, 0, 0,  0, 0, 0, 0, 0);
        add("blink_60",        30, 1, 1, 0, 0,  0, 1, 0, 0, 0);
        add("blink_90",        30, 1, 1, 0, 0,  0, 0, 0, 0, 0);
        add("blink_120",       30, 1, 1, 0, 0,  0, 1, 0, 0, 0);
        add("deb_hi2",          2, 1, 1, 1, 0,  0, 1, 0, 0, 0);
        add("deb_lo1",          1, 1, 1, 0, 0,  0, 1, 0, 0, 0);
        add("deb_hi2b",         2, 1, 1, 1, 0,  0, 1, 0, 0, 0);
        add("deb_hi3",          1, 1, 1, 1, 0,  1, 1, 3, 3, 1);
        add("deb_grst_1cyc",    1, 1, 0, 1, 0,  1, 1, 3, 3, 0);
        add("cd_59",           59, 1, 1, 1, 0,  1, 1, 3, 3, 0);
        add("cd_60",            1, 1, 1, 1, 0,  1, 1, 2, 3, 0);
        add("cd_120",          60, 1, 1, 1, 0,  1, 1, 1, 3, 0);
        add("cd_179",          59, 1, 1, 1, 0,  1, 1, 1, 3, 0);
        add("cd_180_play",      1, 1, 1, 1, 0,  2, 1, 0, 3, 0);
        add("hit1",             1, 1, 0, 1, 1,  2, 1, 0, 2, 0);
        add("hit2_with_fsync",  1, 1, 1, 1, 1,  2, 1, 0, 1, 0);
        add("hit3_gameover",    1, 1, 0, 1, 1,  3, 1, 0, 0, 0);
        add("hit4_ignored",     1, 1, 0, 1, 1,  3, 1, 0, 0, 0);
        add("go_299",         299, 1, 1, 0, 0,  3, 1, 0, 0, 0);
        add("go_300_start",     1, 1, 1, 0, 0,  0, 1, 0, 0, 0);
        add("wrap_pre_27",     27, 1, 1, 0, 0,  0, 1, 0, 0, 0);
        add("wrap_pre_29",      2, 1, 1, 1, 0,  0, 1, 0, 0, 0);
        add("press_on_wrap",    1, 1, 1, 1, 0,  1, 1, 3, 3, 1);

        foreach (vecs[i]) apply(vecs[i]);

        // Play through to GAME OVER, then reset halfway through the hold.
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        frames(180, 1'b1);
        check("seq_playing", 2, 1, 0, 3, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b1);
            cycle(1'b1, 1'b0, 1'b0, 1'b0);
        end
        check("seq_gameover", 3, 1, 0, 0, 0);
        frames(150, 1'b0);
        check("seq_go_150", 3, 1, 0, 0, 0);
        grst_before = n_grst;
        cycle(1'b0, 1'b1, 1'b1, 1'b1);
        check("seq_mid_reset", 0, 1, 0, 0, 0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        check("seq_post_reset", 0, 1, 0, 0, 0);
        n_total++;
        if (n_grst == grst_before) n_pass++;
        else $display("FAIL seq_no_grst_on_reset: got %0d pulses, want 0", n_grst - grst_before);
        frames(2, 1'b1);
        check("seq_deb_2", 0, 1, 0, 0, 0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        check("seq_deb_3", 1, 1, 3, 3, 1);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);

        n_total++;
        if (n_grst == 4) n_pass++;
        else $display("FAIL grst_pulse_count: got %0d cycles, want 4", n_grst);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/game_flow_ctrl.md
# game_flow_ctrl

- Frame-rate sequencer that owns `game_state` for the whole display pipeline.
- Debounces the start button on frame boundaries.
- Drives the READY UP blink enable and runs a 3-2-1 pre-game countdown.
- Tracks player lives and holds a timed GAME OVER interval before returning to the start screen. Its `game_state` and `show_ready` outputs feed the start-screen overlay and the sprite/playfield renderers; `game_reset` clears gameplay entities.

## Interface
- `LIVES_INIT`, 3: lives loaded at game start (1..3).
- `DEBOUNCE_FRAMES`, 3: consecutive frames `btn_start` must be sampled high to register a press.
- `BLINK_FRAMES`, 30: frames per `show_ready` half-period.
- `STEP_FRAMES`, 60: frames per countdown step.
- `GAMEOVER_FRAMES`, 300: frames GAME_OVER is held.

- `pixel_clk` in 1: pixel clock; the single clock domain.
- `rst_n` in 1: synchronous, active-low reset.
- `fsync` in 1: one-cycle pulse at each frame start.
- `btn_start` in 1: start button level, already synchronized to `pixel_clk`.
- `player_hit` in 1: one-cycle pulse when the player ship is destroyed.
- `game_state` out 2: 0 START_SCREEN, 1 COUNTDOWN, 2 PLAYING, 3 GAME_OVER.
- `show_ready` out 1: READY UP text visible.
- `countdown_val` out 2: current countdown digit (3,2,1); 0 outside COUNTDOWN.
- `lives` out 2: remaining lives.
- `game_reset` out 1: one-cycle pulse that clears gameplay entities.

## Operation
- All outputs are registered.
- Reset values: `game_state`=0, `show_ready`=1, `countdown_val`=0, `lives`=0, `game_reset`=0. All internal counters are 0.

Debounce
- `btn_start` is sampled only on `fsync`.
- Sampled high: `deb_cnt` increments, saturating at `DEBOUNCE_FRAMES`.
- Sampled low: `deb_cnt` clears to 0.
- A press event fires exactly when `deb_cnt` transitions to `DEBOUNCE_FRAMES`. A held button therefore produces exactly one event; a new event requires a release first.
- The debouncer runs in every state.

START_SCREEN
- Each `fsync` advances `frame_cnt`. When it reaches `BLINK_FRAMES`-1, `show_ready` toggles and `frame_cnt` wraps to 0.
- On a press event:
  - `game_state` goes to COUNTDOWN.
  - `countdown_val`=3.
  - `lives`=`LIVES_INIT`.
  - `frame_cnt`=0.
  - `game_reset` pulses for one cycle.

COUNTDOWN
- Each `fsync` advances `frame_cnt`.
- At `STEP_FRAMES`-1, `frame_cnt` wraps to 0 and `countdown_val` decrements.
- The step that would take `countdown_val` from 1 to 0 instead sets `game_state` to PLAYING and `countdown_val` to 0.

PLAYING
- Each `player_hit` decrements `lives`.
- A hit with `lives`==1 sets `lives` to 0, `game_state` to GAME_OVER, and `frame_cnt` to 0.

GAME_OVER
- Each `fsync` advances `frame_cnt`.
- At `GAMEOVER_FRAMES`-1, `game_state` goes to START_SCREEN with `show_ready`=1 and `frame_cnt`=0.

General rules
- `show_ready` is held at 1 in every state other than START_SCREEN.
- `player_hit` is ignored outside PLAYING.
- Press events are ignored outside START_SCREEN.
- Counter widths: `frame_cnt` is $clog2 of the largest frame parameter; `deb_cnt` is $clog2(`DEBOUNCE_FRAMES`+1).

## Timing
- **Latency:** every state or output change appears on the cycle after the qualifying input cycle (`fsync` or `player_hit`).
- **`game_reset`:** high only during the first cycle in which `game_state`==1.
- **Simultaneous `fsync` and `player_hit` in PLAYING:** both are processed in the same cycle. A state exit caused by the hit takes priority.
- **Press event on the same `fsync` as a blink wrap:** the state transition wins, and `show_ready` goes to 1.
- **`rst_n` low in any state:** returns to reset values on the next edge. There is no `game_reset` pulse. `deb_cnt` is cleared, so a held button must be released and pressed again.
- **`fsync` asserted during reset:** ignored.

## Test plan
- **Reset:** hold `rst_n`=0 for 5 cycles with `btn_start`=1 and pulse `fsync` → outputs are 0/1/0/0/0. After release, `game_state` changes only after 3 new high-sampled `fsync`s.
- **Blink:** START_SCREEN, 120 `fsync`s with no button → `show_ready` toggles on the cycle after `fsync` #30, #60, #90, #120 and is 1 after #120.
- **Debounce:** `btn_start` high for 2 frames, low for 1, high for 3 → a single transition to COUNTDOWN after the 3rd consecutive high frame. `game_reset` is high for exactly 1 cycle, `countdown_val`=3, `lives`=3.
- **Countdown:** after entry, `countdown_val` reads 2 after 60 `fsync`s and 1 after 120. After 180 `fsync`s, `game_state`=2 and `countdown_val`=0. The button stays held throughout, with no re-trigger.
- **Lives:** in PLAYING, issue 3 `player_hit` pulses, the 2nd coincident with `fsync` → `lives` goes 3→2→1→0 and `game_state`=3 after the 3rd hit. A 4th hit in GAME_OVER changes nothing.
- **Game over:** 300 `fsync`s in GAME_OVER → `game_state`=0 and `show_ready`=1. A mid-sequence reset at frame 150 returns all outputs to reset values with no `game_reset` pulse.
